muldiv_sched: RTL and testbench

//  Scheduler/sequencer for the shared iterative multiply/divide unit in the 5-stage MIPS pipeline.

---
 rtl/muldiv_sched.sv | 113 +++++++++++
 tb/tb_muldiv_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sched.sv
// Sequencer for the shared iterative MIPS multiply/divide unit: starts it, counts its latency, commits HI/LO.
// Latency: hilo_we pulses N edges after the accepting edge (N = MUL_CYCLES, DIV_CYCLES, or 1 on divide-by-zero).
// Backpressure: stall holds a HI/LO reader in ID, or a second mul/div in EX, while the unit is busy.
module muldiv_sched #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_EX,
    input  logic [1:0] op_EX,
    input  logic       divz_EX,
    input  logic       flush_EX,
    input  logic       mfhilo_ID,
    input  logic       abort,
    output logic       unit_start,
    output logic [1:0] unit_op,
    output logic       hilo_we,
    output logic       busy,
    output logic       stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_WB   = 2'b10
    } state_t;

    // Counter preload values: the counter runs down to zero, so it starts at cycles-1.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       unit_op_q, unit_op_d;
    logic             unit_start_q, unit_start_d;
    logic             hilo_we_q, hilo_we_d;
    logic             accept;

    // A new op is taken only when idle and the EX instruction is not squashed.
    assign accept = (state_q == S_IDLE) && start_EX && !flush_EX;

    // State register and registered outputs; reset drops everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            unit_op_q    <= 2'b00;
            unit_start_q <= 1'b0;
            hilo_we_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            unit_op_q    <= unit_op_d;
            unit_start_q <= unit_start_d;
            hilo_we_q    <= hilo_we_d;
        end
    end

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        unit_op_d    = unit_op_q;
        unit_start_d = 1'b0;
        hilo_we_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d      = S_RUN;
                    unit_op_d    = op_EX;
                    unit_start_d = 1'b1;
                    // Divide by zero leaves HI/LO undefined, so skip straight to commit.
                    if (op_EX[1] && divz_EX) begin
                        cnt_d = '0;
                    end else if (op_EX[1]) begin
                        cnt_d = DIV_LOAD;
                    end else begin
                        cnt_d = MUL_LOAD;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d   = S_WB;
                    hilo_we_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // An abort arriving during the commit cycle must still suppress the write.
    assign hilo_we    = hilo_we_q && !abort;
    assign unit_start = unit_start_q;
    assign unit_op    = unit_op_q;
    assign busy       = (state_q != S_IDLE);
    assign stall      = busy && (mfhilo_ID || start_EX);

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: directed scenarios plus randomized traffic against a latency model.
// Each cycle compares {unit_start, unit_op, hilo_we, busy, stall} to the model; scenarios add timing checks.
// Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_muldiv_sched;

    localparam int MULC = 4;
    localparam int DIVC = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_EX;
    logic [1:0] op_EX;
    logic       divz_EX;
    logic       flush_EX;
    logic       mfhilo_ID;
    logic       abort;
    logic       unit_start;
    logic [1:0] unit_op;
    logic       hilo_we;
    logic       busy;
    logic       stall;

    int total = 0;
    int bad   = 0;

    muldiv_sched #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_EX   (start_EX),
        .op_EX      (op_EX),
        .divz_EX    (divz_EX),
        .flush_EX   (flush_EX),
        .mfhilo_ID  (mfhilo_ID),
        .abort      (abort),
        .unit_start (unit_start),
        .unit_op    (unit_op),
        .hilo_we    (hilo_we),
        .busy       (busy),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    logic [5:0] obs_vec;
    assign obs_vec = {unit_start, unit_op, hilo_we, busy, stall};

    // Reference model: an accepted op occupies the unit for n+1 cycles after its accepting edge;
    // the last of them (k == n) is the commit cycle. abort ends occupancy at the next edge.
    bit         m_busy;
    int         m_k;
    int         m_n;
    logic [1:0] m_op;
    bit         m_start;

    task automatic model_reset();
        m_busy  = 1'b0;
        m_k     = 0;
        m_n     = 0;
        m_op    = 2'b00;
        m_start = 1'b0;
    endtask

    function automatic logic [5:0] expect_now();
        logic we;
        logic st;
        we = m_busy && (m_k == m_n) && !abort;
        st = m_busy && (mfhilo_ID || start_EX);
        return {m_start, m_op, we, m_busy, st};
    endfunction

    task automatic model_edge();
        if (m_busy) begin
            m_start = 1'b0;
            if (abort || m_k == m_n) m_busy = 1'b0;
            else m_k = m_k + 1;
        end else if (start_EX && !flush_EX) begin
            m_busy  = 1'b1;
            m_k     = 0;
            m_n     = (op_EX[1] && divz_EX) ? 1 : (op_EX[1] ? DIVC : MULC);
            m_op    = op_EX;
            m_start = 1'b1;
        end else begin
            m_start = 1'b0;
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] op, input logic dz,
                         input logic fl, input logic mf, input logic ab);
        start_EX  = s;
        op_EX     = op;
        divz_EX   = dz;
        flush_EX  = fl;
        mfhilo_ID = mf;
        abort     = ab;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
        model_reset();
        #3;
        total++;
        if (obs_vec !== 6'b0) begin
            bad++;
            $display("FAIL reset_state got=%b want=%b", obs_vec, 6'b0);
        end
        @(negedge clk);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int hw_at = -1;
        int hw_cnt = 0;
        int last_busy = -1;
        for (int i = 0; i < 9; i++) begin
            drive(i == 0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            total++;
            if (obs_vec !== expect_now()) begin
                bad++;
                $display("FAIL mult cyc=%0d got=%b want=%b", i, obs_vec, expect_now());
            end
            if (hilo_we) begin hw_cnt++; if (hw_at < 0) hw_at = i; end
            if (busy) last_busy = i;
            if (i == 1 && unit_start !== 1'b1) begin
                total++; bad++;
                $display("FAIL mult_start got=%b want=1", unit_start);
            end
            tick();
        end
        total++;
        if (hw_at != 5 || hw_cnt != 1) begin
            bad++;
            $display("FAIL mult_commit at=%0d cnt=%0d want at=5 cnt=1", hw_at, hw_cnt);
        end
        total++;
        if (last_busy != 5) begin
            bad++;
            $display("FAIL mult_busy_end got=%0d want=5", last_busy);
        end
    endtask

    task automatic test_div_mfhi();
        int first_st = -1;
        int last_st = -1;
        int hw_at = -1;
        for (int i = 0; i < 37; i++) begin
            drive(i == 0, 2'b10, 1'b0, 1'b0, i >= 3, 1'b0);
            #1;
            total++;
            if (obs_vec !== expect_now()) begin
                bad++;
                $display("FAIL div_mfhi cyc=%0d got=%b want=%b", i, obs_vec, expect_now());
            end
            if (stall) begin last_st = i; if (first_st < 0) first_st = i; end
            if (hilo_we && hw_at < 0) hw_at = i;
            tick();
        end
        total++;
        if (first_st != 3 || last_st != 33 || hw_at != 33) begin
            bad++;
            $display("FAIL div_mfhi_window first=%0d last=%0d we=%0d want 3/33/33", first_st, last_st, hw_at);
        end
    endtask

    task automatic test_divz();
        int hw_at = -1;
        int last_busy = -1;
        for (int i = 0; i < 6; i++) begin
            drive(i == 0, 2'b10, i == 0, 1'b0, 1'b0, 1'b0);
            #1;
            total++;
            if (obs_vec !== expect_now()) begin
                bad++;
                $display("FAIL divz cyc=%0d got=%b want=%b", i, obs_vec, expect_now());
            end
            if (hilo_we && hw_at < 0) hw_at = i;
            if (busy) last_busy = i;
            tick();
        end
        total++;
        if (hw_at != 2 || last_busy != 2) begin
            bad++;
            $display("FAIL divz_timing we=%0d busy_end=%0d want 2/2", hw_at, last_busy);
        end
    endtask

    task automatic test_back_to_back();
        int starts = 0;
        int stalls = 0;
        int hws = 0;
        for (int i = 0; i < 15; i++) begin
            drive(i <= 6, (i == 0) ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            total++;
            if (obs_vec !== expect_now()) begin
                bad++;
                $display("FAIL b2b cyc=%0d got=%b want=%b", i, obs_vec, expect_now());
            end
            if (unit_start) starts++;
            if (stall) stalls++;
            if (hilo_we) hws++;
            tick();
        end
        total++;
        if (starts != 2 || stalls != 5 || hws != 2) begin
            bad++;
            $display("FAIL b2b_counts starts=%0d stalls=%0d we=%0d want 2/5/2", starts, stalls, hws);
        end
    endtask

    task automatic test_abort();
        int hws = 0;
        int last_busy = -1;
        for (int i = 0; i < 40; i++) begin
            drive(i == 0, 2'b11, 1'b0, 1'b0, 1'b0, i == 11);
            #1;
            total++;
            if (obs_vec !== expect_now()) begin
                bad++;
                $display("FAIL abort cyc=%0d got=%b want=%b", i, obs_vec, expect_now());
            end
            if (hilo_we) hws++;
            if (busy) last_busy = i;
            tick();
        end
        total++;
        if (hws != 0 || last_busy != 11) begin
            bad++;
            $display("FAIL abort_kill we=%0d busy_end=%0d want 0/11", hws, last_busy);
        end
    endtask

    task automatic test_boundaries();
        int hws = 0;
        int hw_at = -1;
        for (int i = 0; i < 10; i++) begin
            // i=0: squashed start; i=1: abort while idle; i=2: real accept; then flush while busy.
            drive(i == 0 || i == 2, 2'b00, 1'b0, i == 0 || i >= 3, 1'b0, i == 1);
            #1;
            total++;
            if (obs_vec !== expect_now()) begin
                bad++;
                $display("FAIL bound cyc=%0d got=%b want=%b", i, obs_vec, expect_now());
            end
            if (i == 1) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL bound_flush_idle busy=%b want=0", busy);
                end
            end
            if (hilo_we) begin hws++; if (hw_at < 0) hw_at = i; end
            tick();
        end
        total++;
        if (hws != 1 || hw_at != 7 || unit_op !== 2'b00) begin
            bad++;
            $display("FAIL bound_commit we=%0d at=%0d op=%b want 1/7/00", hws, hw_at, unit_op);
        end
    endtask

    task automatic test_reset_mid();
        int hw_at = -1;
        for (int i = 0; i < 25; i++) begin
            drive(i == 0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            total++;
            if (obs_vec !== expect_now()) begin
                bad++;
                $display("FAIL rstmid_run cyc=%0d got=%b want=%b", i, obs_vec, expect_now());
            end
            tick();
        end
        drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        total++;
        if (busy !== 1'b1 || stall !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre busy=%b stall=%b want 1/1", busy, stall);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs_vec !== 6'b0) begin
            bad++;
            $display("FAIL rstmid_async got=%b want=%b", obs_vec, 6'b0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            total++;
            if (obs_vec !== expect_now()) begin
                bad++;
                $display("FAIL rstmid_after cyc=%0d got=%b want=%b", i, obs_vec, expect_now());
            end
            if (hilo_we && hw_at < 0) hw_at = i;
            tick();
        end
        total++;
        if (hw_at != 5) begin
            bad++;
            $display("FAIL rstmid_commit at=%0d want=5", hw_at);
        end
    endtask

    task automatic test_random();
        int hws = 0;
        int exp_hws = 0;
        logic [5:0] e;
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom % 3) == 0, 2'($urandom % 4), ($urandom % 5) == 0,
                  ($urandom % 7) == 0, ($urandom % 3) == 0, ($urandom % 20) == 0);
            #1;
            e = expect_now();
            total++;
            if (obs_vec !== e) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, obs_vec, e);
            end
            if (hilo_we) hws++;
            if (e[2]) exp_hws++;
            tick();
        end
        total++;
        if (hws != exp_hws) begin
            bad++;
            $display("FAIL random_commits got=%0d want=%0d", hws, exp_hws);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div_mfhi();
        test_divz();
        test_back_to_back();
        test_abort();
        test_boundaries();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
